// File: rtl/ps2_key_pkg.sv
// Scan-code constants and decoder states shared by the PS/2 arrow-key decoder.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit shift, frame check, timeout.
// Parity is checked only when PARITY_CHECK_EN is defined; done/err are combinational strobes.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       done,
  output logic       err
);
  import ps2_key_pkg::*;

`ifdef PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;

  logic        fall;
  logic        last_bit;
  logic        timeout;
  logic        frame_ok;
  logic [10:0] frame_next;

  // clk_sync[2] is the previous synchronized value used for edge detection.
  always_comb begin
    fall       = clk_sync[2] & ~clk_sync[1];
    frame_next = {data_sync[1], shreg};
    last_bit   = fall && (bit_cnt == 4'd10);
    frame_ok   = ~frame_next[0] & frame_next[10] & (~PARITY_CHECK | (^frame_next[9:1]));
    timeout    = (bit_cnt != 4'd0) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
    data       = frame_next[8:1];
    done       = last_bit & frame_ok;
    err        = (last_bit & ~frame_ok) | timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      shreg     <= '0;
      bit_cnt   <= 4'd0;
      timer     <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (fall) begin
        shreg   <= frame_next[10:1];
        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        timer   <= '0;
      end else if (timeout) begin
        bit_cnt <= 4'd0;
        timer   <= '0;
      end else if (bit_cnt != 4'd0) begin
        timer   <= timer + TW'(1);
      end else begin
        timer   <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_dir_keys.sv
// Left/right arrow-key state from a PS/2 keyboard; decodes E0/F0 prefixed scan codes.
// Build option: PARITY_CHECK_EN enables odd-parity rejection in the frame receiver.
module ps2_dir_keys #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);
  import ps2_key_pkg::*;

  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  dec_state_t state, state_n;
  logic       left_n, right_n, valid_n, err_n;
  logic [7:0] code_n;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (rx_data),
    .done     (rx_done),
    .err      (rx_err)
  );

  // Receiver strobes are combinational, so key_valid and left/right land together.
  always_comb begin
    state_n = state;
    left_n  = left;
    right_n = right;
    code_n  = key_code;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (rx_err) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
    end else if (rx_done) begin
      valid_n = 1'b1;
      code_n  = rx_data;
      unique case (state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_n = ST_EXT;
          else if (rx_data == SC_BRK) state_n = ST_BRK;
        end
        ST_EXT: begin
          state_n = ST_IDLE;
          if (rx_data == SC_BRK)        state_n = ST_EXT_BRK;
          else if (rx_data == SC_LEFT)  left_n  = 1'b1;
          else if (rx_data == SC_RIGHT) right_n = 1'b1;
        end
        ST_EXT_BRK: begin
          state_n = ST_IDLE;
          if (rx_data == SC_LEFT)       left_n  = 1'b0;
          else if (rx_data == SC_RIGHT) right_n = 1'b0;
        end
        ST_BRK: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      left      <= 1'b0;
      right     <= 1'b0;
      key_code  <= 8'h00;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      left      <= left_n;
      right     <= right_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      frame_err <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_dir_keys.sv
// Directed bench for ps2_dir_keys: PS/2 frame driver, scan-code model with expected queue, per-cycle compare.
module tb_ps2_dir_keys;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       left;
  logic       right;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;

  // Expected event: {err, code[7:0], left, right}
  logic [10:0] exp_q[$];
  logic       m_ext, m_brk, m_l, m_r;
  logic [7:0] cur_code;
  logic       cur_l, cur_r;

  ps2_dir_keys #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left      (left),
    .right     (right),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors < 30) $display("FAIL %s: act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- model ----------------
  function automatic void model_frame(input logic [10:0] f);
    logic acc;
    logic [7:0] b;
    b   = f[8:1];
    acc = !f[0] && f[10] && (!PAR_EN || (^f[9:1]));
    if (!acc) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      exp_q.push_back({1'b1, 8'h00, m_l, m_r});
      return;
    end
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (b == 8'h6B) m_l = 1'b1;
        else if (b == 8'h74) m_r = 1'b1;
        m_ext = 1'b0;
      end
    end else if (m_ext && m_brk) begin
      if (b == 8'h6B) m_l = 1'b0;
      else if (b == 8'h74) m_r = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_brk = 1'b0;
    end
    exp_q.push_back({1'b0, b, m_l, m_r});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_start,
                            input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ flip_par, b, bad_start};
    if (nbits == 11) model_frame(f);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    if (nbits == 11) repeat (60) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 11);
  endtask

  task automatic model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_l   = 1'b0;
    m_r   = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      cur_code = 8'h00;
      cur_l    = 1'b0;
      cur_r    = 1'b0;
    end else begin
      if (key_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, key_valid, frame_err}, 32'd0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("event_kind", {30'd0, key_valid, frame_err}, {30'd0, ~e[10], e[10]});
          if (!e[10]) cur_code = e[9:2];
          cur_l = e[1];
          cur_r = e[0];
        end
      end
      check("outputs", {22'd0, key_code, left, right}, {22'd0, cur_code, cur_l, cur_r});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int delta;
    bit seen;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {21'd0, left, right, key_code, key_valid, frame_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Extended left make
    send(8'hE0);
    send(8'h6B);
    check("left_after_e0_6b", {30'd0, left, right}, 32'd2);
    check("code_after_e0_6b", {24'd0, key_code}, 32'h6B);

    // Extended left break
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("left_after_release", {31'd0, left}, 32'd0);

    // Right make, then left make: both held
    send(8'hE0); send(8'h74);
    check("right_after_e0_74", {30'd0, left, right}, 32'd1);
    send(8'hE0); send(8'h6B);
    check("both_held", {30'd0, left, right}, 32'd3);

    // Typematic repeat keeps left
    send(8'hE0); send(8'h6B);
    check("typematic_left", {30'd0, left, right}, 32'd3);

    // Non-extended release does not touch left
    send(8'hF0); send(8'h6B);
    check("plain_break_left", {31'd0, left}, 32'd1);

    // Extended right release, then unrelated bytes
    send(8'hE0); send(8'hF0); send(8'h74);
    check("right_released", {30'd0, left, right}, 32'd2);
    send(8'h1C);
    send(8'hE0); send(8'h1C);
    check("ignored_codes", {30'd0, left, right}, 32'd2);
    check("code_1c", {24'd0, key_code}, 32'h1C);

    // Parity flipped 6B
    send_frame(8'h6B, 1'b1, 1'b0, 1'b0, 11);
`ifdef PARITY_CHECK_EN
    check("parity_err_code_kept", {24'd0, key_code}, 32'h1C);
`else
    check("parity_ignored_code", {24'd0, key_code}, 32'h6B);
`endif
    check("parity_left_kept", {30'd0, left, right}, 32'd2);

    // Bad start and bad stop bits
    send_frame(8'h74, 1'b0, 1'b1, 1'b0, 11);
    send_frame(8'h74, 1'b0, 1'b0, 1'b1, 11);
    check("bad_frames_right", {31'd0, right}, 32'd0);

    // Timeout after 5 bits
    exp_q.push_back({1'b1, 8'h00, m_l, m_r});
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 5);
    seen = 1'b0;
    delta = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = 1'b1;
        delta = cyc - last_fall;
      end
    end
    check("timeout_seen", {31'd0, seen}, 32'd1);
    check("timeout_window", {31'd0, (delta >= 100 && delta <= 110)}, 32'd1);
    repeat (300) @(posedge clk);
    send(8'hE0);
    check("e0_after_timeout", {24'd0, key_code}, 32'hE0);
    send(8'h74);
    check("right_after_timeout", {30'd0, left, right}, 32'd3);

    // Reset mid-frame
    send(8'hE0);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0, 6);
    repeat (5) @(posedge clk);
    reset = 1'b1;
    #1;
    check("midframe_reset_outputs", {21'd0, left, right, key_code, key_valid, frame_err}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    check("after_reset_quiet", {24'd0, key_code}, 32'h00);
    send(8'hE0); send(8'h74);
    check("right_after_reset", {30'd0, left, right}, 32'd1);

    // F0 6B from IDLE, then prove FSM back in IDLE with E0 6B
    send(8'hF0); send(8'h6B);
    check("plain_break_no_left", {30'd0, left, right}, 32'd1);
    send(8'hE0); send(8'h6B);
    check("idle_after_plain_break", {30'd0, left, right}, 32'd3);

    repeat (20) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_dir_keys.md
PS2_DIR_KEYS -- requirements
Module: ps2_dir_keys

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ps2_clk, input, 1 bit: the keyboard clock, asynchronous to clk.
REQ-005 The block SHALL have port ps2_data, input, 1 bit: the keyboard data, asynchronous to clk.
REQ-006 The block SHALL have port left, output, 1 bit: level, high while the left-arrow key is held.
REQ-007 The block SHALL have port right, output, 1 bit: level, high while the right-arrow key is held.
REQ-008 The block SHALL have port key_code, output, 8 bits: the last accepted scan byte.
REQ-009 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when key_code updates.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected as sync value 1 in the previous cycle and 0 in the current cycle.
REQ-012 On each detected falling edge the synchronized ps2_data SHALL be shifted into an 11-bit frame: start, 8 data bits LSB-first, odd parity, stop; a 4-bit bit counter counts 0..10.
REQ-013 On the 11th edge the counter SHALL wrap to 0; the frame is accepted when start=0, stop=1 and the parity is odd; key_code and key_valid update in the cycle after that edge.
REQ-014 A rejected frame SHALL pulse frame_err in the same cycle that an accepted frame would pulse key_valid, SHALL leave key_code unchanged, and SHALL return the decoder to IDLE.
REQ-015 When the bit counter is nonzero and TIMEOUT_CYCLES cycles pass with no falling edge, the counter SHALL clear and frame_err SHALL pulse once; an idle bus (counter 0) never times out.
REQ-016 The decoder FSM SHALL have the states IDLE, EXT, BRK and EXT_BRK, and SHALL act only on accepted bytes.
REQ-017 In IDLE: byte E0 goes to EXT; F0 goes to BRK; any other byte stays in IDLE with no effect on left or right.
REQ-018 In EXT: F0 goes to EXT_BRK; 6B sets left to 1; 74 sets right to 1; any other byte is ignored; the FSM then returns to IDLE.
REQ-019 In EXT_BRK: 6B clears left; 74 clears right; any other byte is ignored; the FSM then returns to IDLE.
REQ-020 In BRK: any byte is consumed and the FSM returns to IDLE; non-extended releases do not affect left or right.
REQ-021 Repeated make codes (typematic repeat) SHALL keep the output at 1; left and right are independent, and both may be 1 at the same time.
REQ-022 left and right SHALL change in the same cycle as the key_valid pulse for the byte that causes the change.

Reset
REQ-023 Asserting reset SHALL immediately set left=0, right=0, key_code=00, key_valid=0, frame_err=0, the bit counter to 0, the timeout counter to 0, the FSM to IDLE, and the synchronizers to 1; reset mid-frame discards the partial frame.

Configuration
REQ-024 With PARITY_CHECK_EN defined, a parity mismatch SHALL reject the frame as in REQ-014; without it, parity SHALL be ignored and only the start and stop bits are checked.

Structure
REQ-025 Package ps2_key_pkg SHALL hold the scan-code constants (E0, F0, 6B, 74) and the decoder-state enumeration.
REQ-026 Sub-module ps2_frame_rx SHALL contain the synchronizer, edge detect, shift register, frame check and timeout, and SHALL output a byte and either a valid or an error pulse; ps2_dir_keys holds the FSM.

Verification
REQ-027 Frames E0, 6B (correct parity) -> key_valid pulses twice, left=1, right=0.
REQ-028 After that, frames E0, F0, 6B -> left=0; frames E0, 74 -> right=1; left and right are both 1 when both keys are pressed.
REQ-029 Frame with data 6B and the parity bit flipped -> frame_err=1 when PARITY_CHECK_EN is defined (key_code keeps its old value); key_valid with key_code=6B when it is not defined.
REQ-030 With TIMEOUT_CYCLES=100, send 5 bits then leave ps2_clk high -> frame_err pulses once after 100 cycles; the next full E0 frame is accepted.
REQ-031 Assert reset after the 6th bit of an E0, 74 sequence -> all outputs are 0 and the FSM is IDLE; a following E0, 74 sets right=1.
REQ-032 Frames F0, 6B (non-extended) -> left is unchanged and the FSM is in IDLE.
